// File: rtl/cache_pkg.sv
// Shared cache definitions: MESI encoding, replacer FSM states and width helpers.
package cache_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    HOLD = 2'd2
  } plru_state_e;

  // Bits needed to index one way of an assoc-way set.
  function automatic int way_w(input int assoc);
    return (assoc > 1) ? $clog2(assoc) : 1;
  endfunction

  // Number of sets addressed by a set index of set_bits bits.
  function automatic int set_count(input int set_bits);
    return 1 << set_bits;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU logic for one set: picks the fill way and computes
// the tree bits after an access. Node k has children 2k+1 / 2k+2; a 0 bit
// means the victim lies in the left (lower-index) half.
module plru_tree
  import cache_pkg::*;
#(
  parameter int a_size = 4
) (
  input  logic [a_size-2:0]        tree,
  input  logic                     hit,
  input  logic [way_w(a_size)-1:0] access_way,
  input  logic [a_size-1:0]        invalid,
  output logic [way_w(a_size)-1:0] victim,
  output logic [a_size-2:0]        next_tree
);

  localparam int WAY_W = way_w(a_size);

  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] target;

  // Walk from the root following the bits to the pseudo-LRU leaf.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin : walk
    int node;
    node     = 0;
    plru_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      plru_way[WAY_W-1-l] = tree[node];
      node = tree[node] ? (2 * node + 2) : (2 * node + 1);
    end
  end

  // Lowest-index invalid way wins over the tree victim.
  always_comb begin
    inv_way = '0;
    for (int n = a_size - 1; n >= 0; n--) begin
      if (invalid[n]) inv_way = WAY_W'(n);
    end
    victim = (|invalid) ? inv_way : plru_way;
    target = hit ? access_way : victim;
  end

  // Point every node on the accessed way's path away from that way.
  always_comb begin : update
    int node;
    node      = 0;
    next_tree = tree;
    for (int l = 0; l < WAY_W; l++) begin
      next_tree[node] = ~target[WAY_W-1-l];
      node = target[WAY_W-1-l] ? (2 * node + 2) : (2 * node + 1);
    end
  end

endmodule

// File: rtl/plru_replacer.sv
// Per-set tree pseudo-LRU replacement tracker: owns the tree storage, the
// INIT/IDLE/HOLD sequencing and the request/response handshakes.
module plru_replacer
  import cache_pkg::*;
#(
  parameter int s_size   = 4,
  parameter int a_size   = 4,
  parameter int protocol = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [s_size-1:0]            req_set,
  input  logic                         req_hit,
  input  logic [way_w(a_size)-1:0]     hit_way,
  input  logic [a_size*protocol-1:0]   way_state,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [way_w(a_size)-1:0]     resp_way,
  output logic                         resp_dirty
);

  localparam int WAY_W = way_w(a_size);
  localparam int SETS  = set_count(s_size);
  localparam int NODES = a_size - 1;

  plru_state_e       state_q, state_d;
  logic [s_size-1:0] init_cnt;
  logic              accept;
  logic [NODES-1:0]  tree_q [SETS];
  logic [NODES-1:0]  cur_tree;
  logic [NODES-1:0]  next_tree;
  logic [a_size-1:0] invalid;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  fill_way;
  logic              fill_dirty;

  // Flag ways currently in state I.
  always_comb begin
    invalid = '0;
    for (int n = 0; n < a_size; n++) begin
      invalid[n] = (way_state[n*protocol +: protocol] == protocol'(MESI_I));
    end
  end

  assign cur_tree = tree_q[req_set];

  plru_tree #(.a_size(a_size)) u_tree (
    .tree       (cur_tree),
    .hit        (req_hit),
    .access_way (hit_way),
    .invalid    (invalid),
    .victim     (victim),
    .next_tree  (next_tree)
  );

  // Response way, and dirty only when a full set evicts a Modified line.
  always_comb begin
    fill_way   = req_hit ? hit_way : victim;
    fill_dirty = !req_hit && !(|invalid) &&
                 (way_state[int'(victim)*protocol +: protocol] == protocol'(MESI_M));
  end

  // Next-state and request-ready decode; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      INIT: if (init_cnt == '1) state_d = IDLE;
      IDLE: req_ready = 1'b1;
      HOLD: begin
        req_ready = resp_ready;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
    accept = req_valid && req_ready && !flush;
    if (accept) state_d = HOLD;
    if (flush)  state_d = INIT;
  end

  // State register and INIT set counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (flush || state_q != INIT) init_cnt <= '0;
      else                          init_cnt <= init_cnt + 1'b1;
    end
  end

  // Response register: loaded on accept, dropped on handshake or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_way   <= '0;
      resp_dirty <= 1'b0;
    end else if (flush) begin
      resp_valid <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_way   <= fill_way;
      resp_dirty <= fill_dirty;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Tree storage: cleared one set per INIT cycle, written on each accept.
  // NOTE: this array is reset as well as swept by INIT because its reset value is architecturally defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (!flush) begin
      if (state_q == INIT) tree_q[init_cnt] <= '0;
      else if (accept)     tree_q[req_set]  <= next_tree;
    end
  end

endmodule

// File: doc/plru_replacer.md
Name: plru_replacer

Overview:
- Per-set tree pseudo-LRU replacement tracker for the set-associative cache. It sits directly downstream of block_selector.
- On a hit, it consumes the selected way and marks that way most-recently-used.
- On a miss, it chooses the fill way: the lowest-index invalid way first, otherwise the PLRU victim. It reports whether the victim is dirty (MESI Modified) so the controller can issue a write-back.

Parameters:
- s_size, 4: set-index width; 2**s_size sets.
- a_size, 4: associativity. Must be a power of 2 and at least 2.
- protocol, 2: MESI state bits per way.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  clears all PLRU state; re-runs initialisation.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready at the rising edge.
- req_set  input  s_size  set index.
- req_hit  input  1  1 = hit (hit_way is valid), 0 = miss.
- hit_way  input  $clog2(a_size)  way from block_selector.
- way_state  input  a_size*protocol  MESI state of each way in the set; way n is in bits [n*protocol +: protocol].
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_way  output  $clog2(a_size)  way that was hit or filled.
- resp_dirty  output  1  1 when a miss evicts a way in state M.

Behaviour:
- MESI encoding: I=0, S=1, E=2, M=3.
- Storage: a_size-1 tree bits per set, held in flops.
- Tree bit 0 is the root. The children of bit k are 2k+1 and 2k+2. A bit value of 0 means the victim is on the left (lower ways).
- Update on any access to way w: every node on w's path is set to point away from w.
- FSM states INIT, IDLE, HOLD.
- Reset values: state=INIT, init counter=0, all tree bits 0, resp_valid=0, resp_way=0, resp_dirty=0, req_ready=0.
- INIT:
  - Clears one set per cycle.
  - After 2**s_size cycles, moves to IDLE.
  - req_ready is 0 throughout.
- req_ready = (state==IDLE) || (state==HOLD && resp_ready).
- On the accept edge:
  - resp_way and resp_dirty are registered and resp_valid goes to 1 (1-cycle latency).
  - The tree bits of req_set are written at the same edge.
  - state becomes HOLD.
- Hit:
  - resp_way = hit_way; resp_dirty = 0.
  - way_state is ignored.
- Miss:
  - If any way is I, resp_way is the lowest-index I way and resp_dirty = 0.
  - Otherwise resp_way is the tree victim and resp_dirty = (victim state == M).
  - The tree is updated toward the chosen way in both cases.
- HOLD:
  - resp_* stay stable while resp_ready = 0.
  - resp_ready = 1 with no new accept: resp_valid=0, go to IDLE.
  - resp_ready = 1 with a simultaneous new accept: the response is replaced next edge and the state stays HOLD (back-to-back throughput of 1 per cycle).
- Back-to-back requests to the same set see the update written by the previous accept.
- flush:
  - Has priority over all other events.
  - resp_valid=0, counter=0, go to INIT.
  - Any in-flight request is dropped and no update is made.
- An asynchronous reset mid-operation restarts INIT.
- Requests presented during INIT are not accepted; req_valid may stay high until accepted.

Decomposition:
- Shared package cache_pkg: MESI enum (I, S, E, M), and way-index and set-index width helpers derived from the parameters.
- Sub-module plru_tree (combinational): inputs tree bits, access way, invalid mask; outputs victim way and next tree bits.
- This module owns the storage, the FSM and the handshake.

Test Plan:
- Reset then release, s_size=4 -> req_ready=0 for 16 cycles, then 1; resp_valid=0 and resp_way=0 throughout.
- Five misses to set 3, all ways S, resp_ready=1 -> resp_way sequence 0,2,1,3,0; resp_dirty=0 each time.
- Miss to set 7, way_state {M,I,M,M} for ways 3..0 -> resp_way=2, dirty=0. Then a miss with all ways M on a fresh set -> resp_way=0, dirty=1.
- Hit way 0 on set 5, then miss set 5 (all S) -> resp_way=2. Then miss set 6 -> resp_way=0 (sets are independent).
- Response pending with resp_ready=0 for 3 cycles and a second request waiting -> resp_way/resp_dirty stable, req_ready=0. Raise resp_ready -> second request accepted that edge and its response appears the next cycle.
- Three misses on set 2, then flush for 1 cycle with a request pending -> resp_valid=0 and 16 INIT cycles. Next miss on set 2 -> resp_way=0.
